// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the core load/store port. Accepts
//               one request at a time, optionally inserts wait states, then
//               performs a byte-lane store or a word load on an internal
//               word array and returns a one-cycle response. Drives a
//               load/store hold back to the core while a request is busy.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,

    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,

    output logic        hold_o
);

    // Word-index width and the byte span covered by the array.
    localparam int          c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN      = 33'(DEPTH_WORDS) << 2;
    // Counter preload so that WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;

    logic [3:0]      r_cnt;
    logic            r_wen;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_mask;

    logic [31:0]     r_mem [DEPTH_WORDS];

    logic [31:0]     w_offset;
    logic            w_in_range;
    logic [c_AW-1:0] w_index;
    logic            w_mask_ok;
    logic            w_err;
    logic            w_do_write;

    // ------------------------------------------------------------------------
    // Address decode and error classification on the latched request
    // ------------------------------------------------------------------------
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_offset} < c_SPAN);
    assign w_index    = w_offset[c_AW+1:2];

    // Legal store masks: none, single byte, aligned halfword, full word.
    always_comb begin
        w_mask_ok = 1'b0;
        case (r_mask)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: w_mask_ok = 1'b1;
            default:                            w_mask_ok = 1'b0;
        endcase
    end

    assign w_err      = !w_in_range || (r_wen && !w_mask_ok);
    assign w_do_write = (r_state == S_ACCESS) && r_wen && !w_err;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register; reset aborts any outstanding transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        hold_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                hold_o      = req_valid_i;
                if (req_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                hold_o = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                hold_o       = 1'b1;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                // Hold drops here so the core advances in the response cycle.
                rsp_valid_o  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch and wait counter
    // ------------------------------------------------------------------------
    // Capture the request only at the accept edge; inputs are ignored after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen   <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_mask  <= 4'd0;
        end else if (w_accept) begin
            r_wen   <= req_wen_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_mask  <= req_wmask_i;
        end
    end

    // Wait-state counter: preloaded on accept, counts down while in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= c_WAIT_INIT;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Storage and response
    // ------------------------------------------------------------------------
    // Byte-lane write on the ACCESS exit edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (r_mask[k]) begin
                    r_mem[w_index][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    // Response data/error are registered on the ACCESS exit edge and then
    // held until the next access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            if (w_err) begin
                rsp_rdata_o <= 32'd0;
                rsp_err_o   <= 1'b1;
            end else if (r_wen) begin
                rsp_rdata_o <= 32'd0;
                rsp_err_o   <= 1'b0;
            end else begin
                rsp_rdata_o <= r_mem[w_index];
                rsp_err_o   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
